// File: rtl/ddc_iq_packetizer.sv
// DDC I&Q packetizer: drains one frame of 6-byte I/Q samples from a show-ahead
// byte FIFO, prepends the 16-byte DDC header and streams the packet byte-wise
// to the Ethernet TX arbiter under request/grant and valid/ready control.
module ddc_iq_packetizer #(
  parameter int SAMPLES_PER_FRAME = 238,
  parameter int BITS_PER_SAMPLE   = 24,
  parameter int FIFO_AW           = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [63:0]        ts_in,
  input  logic [FIFO_AW-1:0] fifo_rdusedw,
  input  logic [7:0]         fifo_rdata,
  output logic               fifo_rdreq,
  output logic               tx_req,
  input  logic               tx_grant,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [31:0]        seq_num
);

  localparam int PAYLOAD = SAMPLES_PER_FRAME * 6;
  localparam int HDR_LEN = 16;
  localparam int TOTAL   = HDR_LEN + PAYLOAD;

  localparam logic [10:0]        HDR_LAST   = 11'(HDR_LEN - 1);
  localparam logic [10:0]        TOTAL_LAST = 11'(TOTAL - 1);
  localparam logic [FIFO_AW-1:0] PAYLOAD_W  = FIFO_AW'(PAYLOAD);
  localparam logic [15:0]        BPS_W      = 16'(BITS_PER_SAMPLE);
  localparam logic [15:0]        SPF_W      = 16'(SAMPLES_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] byte_cnt;
  logic [63:0] ts_reg;
  logic [7:0]  hdr_byte;
  logic        xfer;
  logic        start;

  // A whole payload must already be buffered, so the data phase can never underflow.
  assign start = run && (fifo_rdusedw >= PAYLOAD_W);
  assign xfer  = tx_valid && tx_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; the header and data phases only advance on a transfer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_REQ;
      S_REQ:   if (tx_grant) state_next = S_HDR;
      S_HDR:   if (xfer && (byte_cnt == HDR_LAST)) state_next = S_DATA;
      S_DATA:  if (xfer && (byte_cnt == TOTAL_LAST)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stream outputs; the pop is suppressed during reset so an abort leaves the FIFO intact.
  always_comb begin
    tx_valid   = (state == S_HDR) || (state == S_DATA);
    tx_data    = (state == S_DATA) ? fifo_rdata : hdr_byte;
    tx_last    = (state == S_DATA) && (byte_cnt == TOTAL_LAST);
    fifo_rdreq = (state == S_DATA) && tx_ready && !reset;
  end

  // Big-endian header byte selected by the byte counter.
  always_comb begin
    hdr_byte = 8'h00;
    case (byte_cnt[3:0])
      4'd0:  hdr_byte = seq_num[31:24];
      4'd1:  hdr_byte = seq_num[23:16];
      4'd2:  hdr_byte = seq_num[15:8];
      4'd3:  hdr_byte = seq_num[7:0];
      4'd4:  hdr_byte = ts_reg[63:56];
      4'd5:  hdr_byte = ts_reg[55:48];
      4'd6:  hdr_byte = ts_reg[47:40];
      4'd7:  hdr_byte = ts_reg[39:32];
      4'd8:  hdr_byte = ts_reg[31:24];
      4'd9:  hdr_byte = ts_reg[23:16];
      4'd10: hdr_byte = ts_reg[15:8];
      4'd11: hdr_byte = ts_reg[7:0];
      4'd12: hdr_byte = BPS_W[15:8];
      4'd13: hdr_byte = BPS_W[7:0];
      4'd14: hdr_byte = SPF_W[15:8];
      4'd15: hdr_byte = SPF_W[7:0];
    endcase
  end

  // Request, timestamp capture, byte counting and per-packet sequence number.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_req   <= 1'b0;
      seq_num  <= 32'd0;
      byte_cnt <= 11'd0;
      ts_reg   <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!run) seq_num <= 32'd0;
          if (start) begin
            ts_reg <= ts_in;
            tx_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (tx_grant) byte_cnt <= 11'd0;
        end
        S_HDR, S_DATA: begin
          if (xfer) byte_cnt <= byte_cnt + 11'd1;
        end
        S_DONE: begin
          tx_req  <= 1'b0;
          seq_num <= seq_num + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddc_iq_packetizer.sv
// Bench for ddc_iq_packetizer: a show-ahead FIFO model holding a 0x00..0xFF
// ramp, an expected-packet model built from header rules plus the FIFO ramp,
// and directed scenarios for flow control, thresholds, wrap, run drop and reset.
module tb_ddc_iq_packetizer;

  localparam int SPF     = 238;
  localparam int BPS     = 24;
  localparam int AW      = 13;
  localparam int PAYLOAD = SPF * 6;
  localparam int HDR_LEN = 16;
  localparam int TOTAL   = HDR_LEN + PAYLOAD;

  logic          clock;
  logic          reset;
  logic          run;
  logic [63:0]   ts_in;
  logic [AW-1:0] fifo_rdusedw;
  logic [7:0]    fifo_rdata;
  logic          fifo_rdreq;
  logic          tx_req;
  logic          tx_grant;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;
  logic [31:0]   seq_num;

  int errors = 0;
  int checks = 0;
  int fill_total = 0;
  int rd_ptr = 0;
  logic [7:0] exp_bytes [0:TOTAL-1];

  ddc_iq_packetizer #(
    .SAMPLES_PER_FRAME(SPF),
    .BITS_PER_SAMPLE(BPS),
    .FIFO_AW(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .ts_in(ts_in),
    .fifo_rdusedw(fifo_rdusedw),
    .fifo_rdata(fifo_rdata),
    .fifo_rdreq(fifo_rdreq),
    .tx_req(tx_req),
    .tx_grant(tx_grant),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_last(tx_last),
    .seq_num(seq_num)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO model: head byte is the low byte of the read pointer, level is written minus read.
  assign fifo_rdusedw = AW'(fill_total - rd_ptr);
  assign fifo_rdata   = 8'(rd_ptr);

  // Pop the FIFO model on each read request.
  always @(posedge clock) begin
    if (fifo_rdreq) rd_ptr <= rd_ptr + 1;
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int add_bytes, input logic run_val);
    fill_total = fill_total + add_bytes;
    run = run_val;
  endtask

  // Expected packet: header from the field rules, payload from the FIFO ramp.
  task automatic build_expected(input logic [31:0] seq, input logic [63:0] ts, input int start_ptr);
    for (int i = 0; i < 4; i++) exp_bytes[i] = seq[31-8*i -: 8];
    for (int i = 0; i < 8; i++) exp_bytes[4+i] = ts[63-8*i -: 8];
    exp_bytes[12] = 8'(BPS / 256);
    exp_bytes[13] = 8'(BPS % 256);
    exp_bytes[14] = 8'(SPF / 256);
    exp_bytes[15] = 8'(SPF % 256);
    for (int k = 0; k < PAYLOAD; k++) exp_bytes[HDR_LEN+k] = 8'((start_ptr + k) % 256);
  endtask

  // Per-cycle compare against the expected packet, with grant, ready pattern, run drop and reset injection.
  task automatic watch_packet(input bit toggle, input int drop_at, input int reset_at, output int sent);
    int  idx;
    int  req_seen;
    int  cyc;
    bit  done;
    bit  ready_now;
    idx = 0;
    req_seen = 0;
    cyc = 0;
    done = 1'b0;
    sent = 0;
    while (!done && cyc < 8000) begin
      @(negedge clock);
      cyc++;
      if (tx_req && !tx_grant) begin
        req_seen++;
        if (req_seen == 3) tx_grant = 1'b1;
      end
      ready_now = toggle ? (cyc % 2 == 0) : 1'b1;
      if (reset_at >= 0 && idx == reset_at) ready_now = 1'b0;
      tx_ready = ready_now;
      if (drop_at >= 0 && idx == drop_at) run = 1'b0;
      if (reset_at >= 0 && idx == reset_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tx_grant = 1'b0;
        tx_ready = 1'b1;
        #1;
        check_output("abort_valid", 64'(tx_valid), 64'd0);
        check_output("abort_req", 64'(tx_req), 64'd0);
        check_output("abort_last", 64'(tx_last), 64'd0);
        check_output("abort_rdreq", 64'(fifo_rdreq), 64'd0);
        check_output("abort_seq", 64'(seq_num), 64'd0);
        sent = idx;
        return;
      end
      #1;
      if (tx_valid) begin
        check_output("tx_data", 64'(tx_data), 64'(exp_bytes[idx]));
        check_output("tx_last", 64'(tx_last), 64'(idx == TOTAL - 1));
        check_output("fifo_rdreq", 64'(fifo_rdreq), 64'((idx >= HDR_LEN) && tx_ready));
        if (tx_ready) begin
          idx++;
          if (idx == TOTAL) done = 1'b1;
        end
      end else begin
        if (idx > 0) check_output("valid_gap", 64'(tx_valid), 64'd1);
        check_output("idle_rdreq", 64'(fifo_rdreq), 64'd0);
        check_output("idle_last", 64'(tx_last), 64'd0);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL packet_timeout: actual=%0d bytes required=%0d bytes", idx, TOTAL);
    end
    tx_grant = 1'b0;
    tx_ready = 1'b1;
    sent = idx;
  endtask

  // The cycle after the last byte is DONE; the one after that is IDLE with the bumped sequence.
  task automatic post_packet(input logic [31:0] exp_seq);
    @(negedge clock);
    #1;
    check_output("done_valid", 64'(tx_valid), 64'd0);
    check_output("done_last", 64'(tx_last), 64'd0);
    @(negedge clock);
    #1;
    check_output("seq_after", 64'(seq_num), 64'(exp_seq));
    check_output("req_dropped", 64'(tx_req), 64'd0);
  endtask

  initial begin
    int sent;
    int start_ptr;
    reset = 1'b1;
    run = 1'b0;
    ts_in = 64'h0123_4567_89AB_CDEF;
    tx_grant = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_output("rst_req", 64'(tx_req), 64'd0);
    check_output("rst_valid", 64'(tx_valid), 64'd0);
    check_output("rst_last", 64'(tx_last), 64'd0);
    check_output("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    check_output("rst_seq", 64'(seq_num), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] full-rate packet");
    start_ptr = rd_ptr;
    build_expected(32'd0, ts_in, start_ptr);
    check_output("model_hdr_hi", {exp_bytes[0], exp_bytes[1], exp_bytes[2], exp_bytes[3],
                                  exp_bytes[4], exp_bytes[5], exp_bytes[6], exp_bytes[7]},
                 64'h0000_0000_0123_4567);
    check_output("model_hdr_lo", {exp_bytes[8], exp_bytes[9], exp_bytes[10], exp_bytes[11],
                                  exp_bytes[12], exp_bytes[13], exp_bytes[14], exp_bytes[15]},
                 64'h89AB_CDEF_0018_00EE);
    check_output("model_pay_end", 64'(exp_bytes[TOTAL-1]), 64'h93);
    apply_stimulus(PAYLOAD, 1'b1);
    watch_packet(1'b0, -1, -1, sent);
    check_output("sent_full", 64'(sent), 64'd1444);
    post_packet(32'd1);
    check_output("pops_full", 64'(rd_ptr - start_ptr), 64'd1428);

    $display("[TB] threshold and stalled packet");
    apply_stimulus(PAYLOAD - 1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      check_output("short_no_req", 64'(tx_req), 64'd0);
    end
    @(negedge clock);
    apply_stimulus(1, 1'b1);
    @(negedge clock);
    #1;
    check_output("req_rise", 64'(tx_req), 64'd1);
    start_ptr = rd_ptr;
    build_expected(32'd1, ts_in, start_ptr);
    watch_packet(1'b1, -1, -1, sent);
    check_output("sent_toggle", 64'(sent), 64'd1444);
    post_packet(32'd2);
    check_output("pops_toggle", 64'(rd_ptr - start_ptr), 64'd1428);

    $display("[TB] sequence wrap");
    ts_in = 64'hFEDC_BA98_7654_3210;
    @(negedge clock);
    force dut.seq_num = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.seq_num;
    #1;
    check_output("seq_forced", 64'(seq_num), 64'hFFFF_FFFF);
    start_ptr = rd_ptr;
    build_expected(32'hFFFF_FFFF, ts_in, start_ptr);
    check_output("model_wrap_hdr", {exp_bytes[0], exp_bytes[1], exp_bytes[2], exp_bytes[3]}, 64'hFFFF_FFFF);
    apply_stimulus(PAYLOAD, 1'b1);
    watch_packet(1'b0, -1, -1, sent);
    post_packet(32'd0);

    $display("[TB] run drop mid-packet");
    start_ptr = rd_ptr;
    build_expected(32'd0, ts_in, start_ptr);
    apply_stimulus(PAYLOAD, 1'b1);
    watch_packet(1'b0, 500, -1, sent);
    check_output("sent_drop", 64'(sent), 64'd1444);
    post_packet(32'd1);
    @(negedge clock);
    #1;
    check_output("seq_cleared", 64'(seq_num), 64'd0);
    apply_stimulus(PAYLOAD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      check_output("stopped_no_req", 64'(tx_req), 64'd0);
    end

    $display("[TB] reset mid-packet");
    start_ptr = rd_ptr;
    build_expected(32'd0, ts_in, start_ptr);
    apply_stimulus(0, 1'b1);
    watch_packet(1'b0, -1, 800, sent);
    check_output("sent_abort", 64'(sent), 64'd800);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check_output("post_abort_req", 64'(tx_req), 64'd0);
      check_output("post_abort_valid", 64'(tx_valid), 64'd0);
    end
    check_output("pops_abort", 64'(rd_ptr - start_ptr), 64'd784);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
